axis_width_adapter: RTL and testbench

- Parametrised AXI-Stream byte-lane gearbox between a stream source and the processor/DMA side.
- Repacks input beats of INP_TDATA_WIDTH_BYTES into output beats of OUT_TDATA_WIDTH_BYTES, honouring tkeep and tlast.
- Packets are never merged; each output packet carries exactly the kept bytes of one input packet, in order.

---
 rtl/axis_adapter_pkg.sv | 33 +++
 rtl/axis_byte_shift_buffer.sv | 60 ++++++
 rtl/axis_width_adapter.sv | 132 +++++++++++++
 tb/tb_axis_width_adapter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_adapter_pkg.sv
// Shared helpers for the AXI-Stream byte-lane gearbox: buffer sizing and keep-mask decoding.
// Optional statistics counters in the top are enabled by AXIS_WIDTH_ADAPTER_STATS_EN.
package axis_adapter_pkg;

  typedef struct packed {
    logic last_held;
    logic zlast;
  } pkt_flags_t;

  function automatic int cap_bytes(input int inp, input int out);
    return inp + out;
  endfunction

  function automatic int cnt_width(input int cap);
    return $clog2(cap + 1);
  endfunction

  // Only the run of ones starting at lane 0 counts; anything above the first hole is ignored.
  function automatic int keep_to_count(input logic [63:0] keep, input int width);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < width && run) begin
        if (keep[i]) n++;
        else         run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_byte_shift_buffer.sv
// Byte buffer that shifts out the emitted head and appends new bytes at the post-shift tail,
// both in the same cycle.
module axis_byte_shift_buffer
  import axis_adapter_pkg::*;
#(
  parameter int INP_BYTES = 4,
  parameter int OUT_BYTES = 4,
  parameter int CAP_BYTES = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic [CNT_W-1:0]       i_shift,
  input  logic [INP_BYTES*8-1:0] i_app_data,
  input  logic [INP_BYTES-1:0]   i_app_keep,
  input  logic [CNT_W-1:0]       i_app_cnt,
  output logic [CNT_W-1:0]       o_base,
  output logic [OUT_BYTES*8-1:0] o_head,
  output logic [CNT_W-1:0]       o_count
);

  logic [CAP_BYTES*8-1:0] r_buf;
  logic [CAP_BYTES*8-1:0] w_shifted;
  logic [CAP_BYTES*8-1:0] w_lane_msk;
  logic [CAP_BYTES*8-1:0] w_app_msk;
  logic [CAP_BYTES*8-1:0] w_app;
  logic [CAP_BYTES*8-1:0] w_nxt;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_base;

  assign w_base    = r_count - i_shift;
  assign w_shifted = r_buf >> {i_shift, 3'b000};

  always_comb begin
    w_lane_msk = '0;
    for (int i = 0; i < INP_BYTES; i++) begin
      w_lane_msk[i*8 +: 8] = {8{i_app_keep[i]}};
    end
  end

  // Append lanes land at the tail left after this cycle's shift.
  assign w_app_msk = w_lane_msk << {w_base, 3'b000};
  assign w_app     = {{(CAP_BYTES-INP_BYTES)*8{1'b0}}, i_app_data} << {w_base, 3'b000};
  assign w_nxt     = (w_shifted & ~w_app_msk) | (w_app & w_app_msk);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      r_buf   <= w_nxt;
      r_count <= w_base + i_app_cnt;
    end
  end

  assign o_base  = w_base;
  assign o_head  = r_buf[OUT_BYTES*8-1:0];
  assign o_count = r_count;

endmodule

// File: rtl/axis_width_adapter.sv
// AXI-Stream byte-lane gearbox: repacks kept input bytes into output beats, one packet at a time.
// Define AXIS_WIDTH_ADAPTER_STATS_EN to add stat_pkts/stat_bytes counters.
module axis_width_adapter
  import axis_adapter_pkg::*;
#(
  parameter int INP_TDATA_WIDTH_BYTES = 4,
  parameter int OUT_TDATA_WIDTH_BYTES = 4
) (
  input  logic                               clk,
  input  logic                               arstn,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  input  logic [INP_TDATA_WIDTH_BYTES*8-1:0] s_tdata,
  input  logic [INP_TDATA_WIDTH_BYTES-1:0]   s_tkeep,
  input  logic                               s_tlast,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [OUT_TDATA_WIDTH_BYTES*8-1:0] m_tdata,
  output logic [OUT_TDATA_WIDTH_BYTES-1:0]   m_tkeep,
  output logic                               m_tlast
`ifdef AXIS_WIDTH_ADAPTER_STATS_EN
  ,
  output logic [31:0]                        stat_pkts,
  output logic [31:0]                        stat_bytes
`endif
);

  localparam int INP   = INP_TDATA_WIDTH_BYTES;
  localparam int OUT   = OUT_TDATA_WIDTH_BYTES;
  localparam int CAP   = cap_bytes(INP, OUT);
  localparam int CNT_W = cnt_width(CAP);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT);

  pkt_flags_t       r_flags, w_flags_nxt;
  logic             r_rdy_en;
  logic [CNT_W-1:0] w_count, w_base, w_n_out, w_shift, w_n_in, w_cnt_nxt;
  logic [INP-1:0]   w_app_keep;
  logic             w_mvalid, w_mlast, w_emit, w_accept;
  int               w_keep_n;

  axis_byte_shift_buffer #(
    .INP_BYTES (INP),
    .OUT_BYTES (OUT),
    .CAP_BYTES (CAP),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk        (clk),
    .arstn      (arstn),
    .i_shift    (w_shift),
    .i_app_data (s_tdata),
    .i_app_keep (w_app_keep),
    .i_app_cnt  (w_n_in),
    .o_base     (w_base),
    .o_head     (m_tdata),
    .o_count    (w_count)
  );

  // Output side is decoded from registered state only, never from m_tready.
  assign w_n_out  = (w_count >= OUT_C) ? OUT_C : w_count;
  assign w_mvalid = (w_count >= OUT_C) | (r_flags.last_held & (w_count != '0)) | r_flags.zlast;
  assign w_mlast  = (r_flags.last_held & (w_count <= OUT_C)) | r_flags.zlast;
  assign w_emit   = w_mvalid & m_tready;
  assign w_shift  = w_emit ? w_n_out : '0;

  always_comb begin
    m_tkeep = '0;
    for (int i = 0; i < OUT; i++) begin
      m_tkeep[i] = (32'(i) < 32'(w_n_out));
    end
  end

  assign m_tvalid = w_mvalid;
  assign m_tlast  = w_mlast;

  // Room is judged after this cycle's emit, so a full buffer can drain and refill together.
  assign s_tready = r_rdy_en & ~r_flags.last_held & ~r_flags.zlast
                  & (32'(w_base) + 32'(INP) <= 32'(CAP));
  assign w_accept = s_tvalid & s_tready;
  assign w_keep_n = keep_to_count(64'(s_tkeep), INP);
  assign w_n_in   = w_accept ? CNT_W'(w_keep_n) : '0;
  assign w_cnt_nxt = w_base + w_n_in;

  always_comb begin
    w_app_keep = '0;
    for (int i = 0; i < INP; i++) begin
      w_app_keep[i] = w_accept && (i < w_keep_n);
    end
  end

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_emit && w_mlast) begin
      w_flags_nxt.last_held = 1'b0;
      w_flags_nxt.zlast     = 1'b0;
    end
    // A tlast beat that leaves nothing buffered still owes the sink an empty last beat.
    if (w_accept && s_tlast) begin
      if (w_cnt_nxt != '0) w_flags_nxt.last_held = 1'b1;
      else                 w_flags_nxt.zlast     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_flags  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_flags  <= w_flags_nxt;
      r_rdy_en <= 1'b1;
    end
  end

`ifdef AXIS_WIDTH_ADAPTER_STATS_EN
  logic [31:0] r_stat_pkts, r_stat_bytes;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_stat_pkts  <= '0;
      r_stat_bytes <= '0;
    end else begin
      if (w_emit && w_mlast) r_stat_pkts <= r_stat_pkts + 32'd1;
      r_stat_bytes <= r_stat_bytes + 32'(w_shift);
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_bytes = r_stat_bytes;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_axis_width_adapter.sv
// Bench for axis_width_adapter: 4->4 table with scoreboard, plus 4->2 and 2->4 repack sequences.
module tb_axis_width_adapter;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          stall;
    int          nexp;
    beat_t       e0;
    beat_t       e1;
  } vec_t;

  logic clk = 1'b0;
  logic arstn = 1'b0;

  logic        d0_svalid, d0_sready, d0_slast, d0_mvalid, d0_mready, d0_mlast;
  logic [31:0] d0_sdata, d0_mdata;
  logic [3:0]  d0_skeep, d0_mkeep;

  logic        d1_svalid, d1_sready, d1_slast, d1_mvalid, d1_mready, d1_mlast;
  logic [31:0] d1_sdata;
  logic [3:0]  d1_skeep;
  logic [15:0] d1_mdata;
  logic [1:0]  d1_mkeep;

  logic        d2_svalid, d2_sready, d2_slast, d2_mvalid, d2_mready, d2_mlast;
  logic [15:0] d2_sdata;
  logic [1:0]  d2_skeep;
  logic [31:0] d2_mdata;
  logic [3:0]  d2_mkeep;

`ifdef AXIS_WIDTH_ADAPTER_STATS_EN
  logic [31:0] d0_sp, d0_sb, d1_sp, d1_sb, d2_sp, d2_sb;
`endif

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  axis_width_adapter #(.INP_TDATA_WIDTH_BYTES(4), .OUT_TDATA_WIDTH_BYTES(4)) dut0 (
    .clk(clk), .arstn(arstn),
    .s_tvalid(d0_svalid), .s_tready(d0_sready), .s_tdata(d0_sdata), .s_tkeep(d0_skeep), .s_tlast(d0_slast),
    .m_tvalid(d0_mvalid), .m_tready(d0_mready), .m_tdata(d0_mdata), .m_tkeep(d0_mkeep), .m_tlast(d0_mlast)
`ifdef AXIS_WIDTH_ADAPTER_STATS_EN
    , .stat_pkts(d0_sp), .stat_bytes(d0_sb)
`endif
  );

  axis_width_adapter #(.INP_TDATA_WIDTH_BYTES(4), .OUT_TDATA_WIDTH_BYTES(2)) dut1 (
    .clk(clk), .arstn(arstn),
    .s_tvalid(d1_svalid), .s_tready(d1_sready), .s_tdata(d1_sdata), .s_tkeep(d1_skeep), .s_tlast(d1_slast),
    .m_tvalid(d1_mvalid), .m_tready(d1_mready), .m_tdata(d1_mdata), .m_tkeep(d1_mkeep), .m_tlast(d1_mlast)
`ifdef AXIS_WIDTH_ADAPTER_STATS_EN
    , .stat_pkts(d1_sp), .stat_bytes(d1_sb)
`endif
  );

  axis_width_adapter #(.INP_TDATA_WIDTH_BYTES(2), .OUT_TDATA_WIDTH_BYTES(4)) dut2 (
    .clk(clk), .arstn(arstn),
    .s_tvalid(d2_svalid), .s_tready(d2_sready), .s_tdata(d2_sdata), .s_tkeep(d2_skeep), .s_tlast(d2_slast),
    .m_tvalid(d2_mvalid), .m_tready(d2_mready), .m_tdata(d2_mdata), .m_tkeep(d2_mkeep), .m_tlast(d2_mlast)
`ifdef AXIS_WIDTH_ADAPTER_STATS_EN
    , .stat_pkts(d2_sp), .stat_bytes(d2_sb)
`endif
  );

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic beat_t bt(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    return b;
  endfunction

  function automatic vec_t mkv(input logic [31:0] d, input logic [3:0] k, input logic l,
                               input int stall, input int nexp, input beat_t e0, input beat_t e1);
    vec_t v;
    v.d = d; v.k = k; v.l = l; v.stall = stall; v.nexp = nexp; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives one beat on dut0 and returns the number of cycles it waited for s_tready.
  task automatic send0(input logic [31:0] d, input logic [3:0] k, input logic l, output int waited);
    bit done;
    d0_svalid = 1'b1; d0_sdata = d; d0_skeep = k; d0_slast = l;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (d0_sready) done = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          total++; bad++;
          $display("FAIL send0_timeout: waited %0d cycles, want accept", waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    d0_svalid = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain0_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t  v[11];
    beat_t e;
    int    w, n;

    d0_svalid = 0; d0_sdata = '0; d0_skeep = '0; d0_slast = 0; d0_mready = 1;
    d1_svalid = 0; d1_sdata = '0; d1_skeep = '0; d1_slast = 0; d1_mready = 1;
    d2_svalid = 0; d2_sdata = '0; d2_skeep = '0; d2_slast = 0; d2_mready = 1;

    fork
      forever begin
        @(negedge clk);
        if (arstn && d0_mvalid && d0_mready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL d0_unexpected: got data %h keep %h last %b want no beat", d0_mdata, d0_mkeep, d0_mlast);
          end else begin
            e = exp_q.pop_front();
            chk("d0_data", d0_mdata & kmask(d0_mkeep), e.d & kmask(e.k));
            chk("d0_keep", 32'(d0_mkeep), 32'(e.k));
            chk("d0_last", 32'(d0_mlast), 32'(e.l));
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation ran too long, want finish");
        $fatal(1);
      end
    join_none

    // Reset state.
    #2;
    chk("rst_mvalid", 32'(d0_mvalid), 32'd0);
    chk("rst_mdata",  d0_mdata, 32'd0);
    chk("rst_mkeep",  32'(d0_mkeep), 32'd0);
    chk("rst_mlast",  32'(d0_mlast), 32'd0);
    chk("rst_sready", 32'(d0_sready), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    arstn = 1'b1;
    #1;
    chk("rel_sready_pre_edge", 32'(d0_sready), 32'd0);
    @(posedge clk); #1;
    chk("rel_sready_d0", 32'(d0_sready), 32'd1);
    chk("rel_sready_d1", 32'(d1_sready), 32'd1);
    chk("rel_sready_d2", 32'(d2_sready), 32'd1);

    // 4->4 vectors: input beat, expected stall cycles, and the output beats it completes.
    v[0]  = mkv(32'h03020100, 4'hF, 1'b0, 0, 1, bt(32'h03020100, 4'hF, 1'b0), '0);
    v[1]  = mkv(32'h07060504, 4'hF, 1'b0, 0, 1, bt(32'h07060504, 4'hF, 1'b0), '0);
    v[2]  = mkv(32'h0B0A0908, 4'hF, 1'b1, 0, 1, bt(32'h0B0A0908, 4'hF, 1'b1), '0);
    v[3]  = mkv(32'h000000AA, 4'h1, 1'b1, 1, 1, bt(32'h000000AA, 4'h1, 1'b1), '0);
    v[4]  = mkv(32'h000000BB, 4'h1, 1'b0, 1, 0, '0, '0);
    v[5]  = mkv(32'h00EEDDCC, 4'h7, 1'b1, 0, 1, bt(32'hEEDDCCBB, 4'hF, 1'b1), '0);
    v[6]  = mkv(32'hDEADBEEF, 4'h0, 1'b0, 1, 0, '0, '0);
    v[7]  = mkv(32'h12345678, 4'hD, 1'b1, 0, 1, bt(32'h00000078, 4'h1, 1'b1), '0);
    v[8]  = mkv(32'hCAFEF00D, 4'h0, 1'b1, 1, 1, bt(32'h00000000, 4'h0, 1'b1), '0);
    v[9]  = mkv(32'h99992211, 4'h3, 1'b0, 1, 0, '0, '0);
    v[10] = mkv(32'h66554433, 4'hF, 1'b1, 0, 2, bt(32'h44332211, 4'hF, 1'b0), bt(32'h00006655, 4'h3, 1'b1));

    for (int i = 0; i < 11; i++) begin
      if (v[i].nexp > 0) exp_q.push_back(v[i].e0);
      if (v[i].nexp > 1) exp_q.push_back(v[i].e1);
      send0(v[i].d, v[i].k, v[i].l, w);
      chk($sformatf("vec%0d_stall", i), 32'(w), 32'(v[i].stall));
    end
    drain0();

    // Backpressure: fill to capacity, hold m_tready low, then release.
    @(posedge clk); #1;
    d0_mready = 1'b0;
    exp_q.push_back(bt(32'hA3A2A1A0, 4'hF, 1'b0));
    send0(32'hA3A2A1A0, 4'hF, 1'b0, w);
    chk("bp_stall_a", 32'(w), 32'd0);
    exp_q.push_back(bt(32'hB3B2B1B0, 4'hF, 1'b0));
    send0(32'hB3B2B1B0, 4'hF, 1'b0, w);
    chk("bp_stall_b", 32'(w), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_sready", 32'(d0_sready), 32'd0);
      chk("bp_mvalid", 32'(d0_mvalid), 32'd1);
      chk("bp_mdata",  d0_mdata, 32'hA3A2A1A0);
      chk("bp_mkeep",  32'(d0_mkeep), 32'hF);
      chk("bp_mlast",  32'(d0_mlast), 32'd0);
    end
    @(posedge clk); #1;
    d0_mready = 1'b1;
    exp_q.push_back(bt(32'hC3C2C1C0, 4'hF, 1'b1));
    send0(32'hC3C2C1C0, 4'hF, 1'b1, w);
    chk("bp_stall_c", 32'(w), 32'd0);
    drain0();

    // Reset with a partial packet buffered, then a clean packet.
    send0(32'h00CCBBAA, 4'h7, 1'b0, w);
    chk("prerst_count",  32'(dut0.u_buf.r_count), 32'd3);
    chk("prerst_mvalid", 32'(d0_mvalid), 32'd0);
    #2;
    arstn = 1'b0;
    #1;
    chk("midrst_mvalid", 32'(d0_mvalid), 32'd0);
    chk("midrst_sready", 32'(d0_sready), 32'd0);
    chk("midrst_count",  32'(dut0.u_buf.r_count), 32'd0);
    @(negedge clk); @(negedge clk);
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("postrst_sready", 32'(d0_sready), 32'd1);
    exp_q.push_back(bt(32'h000000DD, 4'h1, 1'b1));
    send0(32'h000000DD, 4'h1, 1'b1, w);
    drain0();

    // 4->2: one beat splits into two.
    @(posedge clk); #1;
    d1_svalid = 1'b1; d1_sdata = 32'h44332211; d1_skeep = 4'hF; d1_slast = 1'b1;
    @(negedge clk);
    chk("d1_sready", 32'(d1_sready), 32'd1);
    @(posedge clk); #1;
    d1_svalid = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d1_mvalid) begin
        if (n == 0) begin
          chk("d1_b0_cycle", 32'(c), 32'd0);
          chk("d1_b0_data", 32'(d1_mdata) & kmask({2'b00, d1_mkeep}), 32'h2211);
          chk("d1_b0_keep", 32'(d1_mkeep), 32'h3);
          chk("d1_b0_last", 32'(d1_mlast), 32'd0);
        end else if (n == 1) begin
          chk("d1_b1_data", 32'(d1_mdata) & kmask({2'b00, d1_mkeep}), 32'h4433);
          chk("d1_b1_keep", 32'(d1_mkeep), 32'h3);
          chk("d1_b1_last", 32'(d1_mlast), 32'd1);
        end
        n++;
      end
    end
    chk("d1_beats", 32'(n), 32'd2);

    // 2->4: two partial beats merge into one short last beat.
    @(posedge clk); #1;
    d2_svalid = 1'b1; d2_sdata = 16'h2211; d2_skeep = 2'h3; d2_slast = 1'b0;
    @(negedge clk);
    chk("d2_sready_a", 32'(d2_sready), 32'd1);
    @(posedge clk); #1;
    d2_sdata = 16'h0033; d2_skeep = 2'h1; d2_slast = 1'b1;
    @(negedge clk);
    chk("d2_sready_b", 32'(d2_sready), 32'd1);
    chk("d2_no_early", 32'(d2_mvalid), 32'd0);
    @(posedge clk); #1;
    d2_svalid = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d2_mvalid) begin
        if (n == 0) begin
          chk("d2_data", d2_mdata & kmask(d2_mkeep), 32'h00332211);
          chk("d2_keep", 32'(d2_mkeep), 32'h7);
          chk("d2_last", 32'(d2_mlast), 32'd1);
        end
        n++;
      end
    end
    chk("d2_beats", 32'(n), 32'd1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
